// File: rtl/dest_tracker.sv
// ----------------------------------------------------------------------------
// dest_tracker
//
// Destination-register tracker for the 5-stage MIPS pipeline. It carries each
// instruction's register-write intent {wena, waddr} from ID through the EX,
// MEM and WB stage registers. These registers feed the stall unit's hazard
// comparisons. A bubble is injected into EX on a stall or a flush.
//
// Ports:
//   in_clk          clock, rising edge
//   in_rst          synchronous active-high reset
//   in_id_valid     ID slot holds a real instruction
//   in_id_wena      ID instruction writes a register
//   in_id_waddr     ID instruction destination register
//   in_stall        stall request; a bubble goes to EX and the edge is counted
//   in_flush        ID instruction killed; a bubble goes to EX
//   out_ex_*        EX stage {wena, waddr}
//   out_mem_*       MEM stage {wena, waddr}
//   out_wb_*        WB stage {wena, waddr}
//   out_bubble_cnt  saturating count of stall bubbles
//   out_pending     per-register in-flight write bitmap  (DEST_TRACK_PENDING_EN)
//   out_inflight    number of stages with wena=1         (DEST_TRACK_PENDING_EN)
//
// Optional feature macro: DEST_TRACK_PENDING_EN
// ----------------------------------------------------------------------------
module dest_tracker #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_id_valid,
    input  logic                 in_id_wena,
    input  logic [ADDR_W-1:0]    in_id_waddr,
    input  logic                 in_stall,
    input  logic                 in_flush,
    output logic                 out_ex_wena,
    output logic [ADDR_W-1:0]    out_ex_waddr,
    output logic                 out_mem_wena,
    output logic [ADDR_W-1:0]    out_mem_waddr,
    output logic                 out_wb_wena,
    output logic [ADDR_W-1:0]    out_wb_waddr,
`ifdef DEST_TRACK_PENDING_EN
    output logic [CNT_W-1:0]     out_bubble_cnt,
    output logic [2**ADDR_W-1:0] out_pending,
    output logic [1:0]           out_inflight
`else
    output logic [CNT_W-1:0]     out_bubble_cnt
`endif
);

    logic              ex_wena,  mem_wena,  wb_wena;
    logic [ADDR_W-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic [CNT_W-1:0]  bubble_cnt;

    logic              entry_wena;
    logic [ADDR_W-1:0] entry_waddr;
    logic              bubble;

    // Writes to $0 never enter the tracker, so a zero waddr is always paired
    // with wena=0.
    always_comb begin
        bubble      = in_stall | in_flush;
        entry_wena  = 1'b0;
        entry_waddr = '0;
        if (!bubble && in_id_valid && in_id_wena && (in_id_waddr != '0)) begin
            entry_wena  = 1'b1;
            entry_waddr = in_id_waddr;
        end
    end

    // MEM and WB advance every cycle; stall only affects what enters EX.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            ex_wena    <= 1'b0;
            ex_waddr   <= '0;
            mem_wena   <= 1'b0;
            mem_waddr  <= '0;
            wb_wena    <= 1'b0;
            wb_waddr   <= '0;
            bubble_cnt <= '0;
        end else begin
            wb_wena   <= mem_wena;
            wb_waddr  <= mem_waddr;
            mem_wena  <= ex_wena;
            mem_waddr <= ex_waddr;
            ex_wena   <= entry_wena;
            ex_waddr  <= entry_waddr;
            if (in_stall && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign out_ex_wena    = ex_wena;
    assign out_ex_waddr   = ex_waddr;
    assign out_mem_wena   = mem_wena;
    assign out_mem_waddr  = mem_waddr;
    assign out_wb_wena    = wb_wena;
    assign out_wb_waddr   = wb_waddr;
    assign out_bubble_cnt = bubble_cnt;

`ifdef DEST_TRACK_PENDING_EN
    // wena=1 implies waddr!=0, so bit 0 of the bitmap can never be set.
    always_comb begin
        out_pending = '0;
        if (ex_wena)  out_pending[ex_waddr]  = 1'b1;
        if (mem_wena) out_pending[mem_waddr] = 1'b1;
        if (wb_wena)  out_pending[wb_waddr]  = 1'b1;
        out_inflight = {1'b0, ex_wena} + {1'b0, mem_wena} + {1'b0, wb_wena};
    end
`endif

endmodule

// File: tb/tb_dest_tracker.sv
// ----------------------------------------------------------------------------
// tb_dest_tracker
//
// Directed bench for dest_tracker. It exercises a default instance and a
// CNT_W=2 instance that share the same stimulus, the latter being used for
// counter saturation.
// ----------------------------------------------------------------------------
module tb_dest_tracker;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic              id_wena;
    logic [ADDR_W-1:0] id_waddr;
    logic              stall;
    logic              flush;

    logic              ex_wena,  mem_wena,  wb_wena;
    logic [ADDR_W-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic [15:0]       bubble_cnt;

    logic              s_ex_wena,  s_mem_wena,  s_wb_wena;
    logic [ADDR_W-1:0] s_ex_waddr, s_mem_waddr, s_wb_waddr;
    logic [1:0]        s_bubble_cnt;

`ifdef DEST_TRACK_PENDING_EN
    logic [31:0]       pending,  s_pending;
    logic [1:0]        inflight, s_inflight;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dest_tracker #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_id_valid   (id_valid),
        .in_id_wena    (id_wena),
        .in_id_waddr   (id_waddr),
        .in_stall      (stall),
        .in_flush      (flush),
        .out_ex_wena   (ex_wena),
        .out_ex_waddr  (ex_waddr),
        .out_mem_wena  (mem_wena),
        .out_mem_waddr (mem_waddr),
        .out_wb_wena   (wb_wena),
        .out_wb_waddr  (wb_waddr),
`ifdef DEST_TRACK_PENDING_EN
        .out_bubble_cnt(bubble_cnt),
        .out_pending   (pending),
        .out_inflight  (inflight)
`else
        .out_bubble_cnt(bubble_cnt)
`endif
    );

    dest_tracker #(.ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_id_valid   (id_valid),
        .in_id_wena    (id_wena),
        .in_id_waddr   (id_waddr),
        .in_stall      (stall),
        .in_flush      (flush),
        .out_ex_wena   (s_ex_wena),
        .out_ex_waddr  (s_ex_waddr),
        .out_mem_wena  (s_mem_wena),
        .out_mem_waddr (s_mem_waddr),
        .out_wb_wena   (s_wb_wena),
        .out_wb_waddr  (s_wb_waddr),
`ifdef DEST_TRACK_PENDING_EN
        .out_bubble_cnt(s_bubble_cnt),
        .out_pending   (s_pending),
        .out_inflight  (s_inflight)
`else
        .out_bubble_cnt(s_bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {wena, waddr} of one stage packed as wena*256 + waddr for compact checks
    task automatic check_stage(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                               input logic ew, input int ea);
        check(tag, {23'd0, w, 3'd0, a}, {23'd0, ew, 8'(ea)});
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic s, input logic f);
        id_valid = v;
        id_wena  = w;
        id_waddr = ADDR_W'(a);
        stall    = s;
        flush    = f;
    endtask

    // advance one rising edge and settle #1 after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 1, 8, 0, 0);
        #2;

        // Reset held 2 cycles with a live ID instruction
        for (int i = 0; i < 2; i++) begin
            tick();
            check_stage("rst_ex",  ex_wena,  ex_waddr,  0, 0);
            check_stage("rst_mem", mem_wena, mem_waddr, 0, 0);
            check_stage("rst_wb",  wb_wena,  wb_waddr,  0, 0);
            check("rst_cnt", 32'(bubble_cnt), 0);
        end
`ifdef DEST_TRACK_PENDING_EN
        check("rst_pending",  pending, 0);
        check("rst_inflight", 32'(inflight), 0);
`endif
        rst = 1'b0;

        // Straight flow $8, $9, $10
        drive(1, 1, 8, 0, 0);  tick();
        check_stage("flow_ex1", ex_wena, ex_waddr, 1, 8);
        drive(1, 1, 9, 0, 0);  tick();
        drive(1, 1, 10, 0, 0); tick();
        check_stage("flow_ex",  ex_wena,  ex_waddr,  1, 10);
        check_stage("flow_mem", mem_wena, mem_waddr, 1, 9);
        check_stage("flow_wb",  wb_wena,  wb_waddr,  1, 8);
`ifdef DEST_TRACK_PENDING_EN
        check("flow_pending",  pending, 32'h700);
        check("flow_inflight", 32'(inflight), 3);
`endif

        // 2-cycle stall: EX 8, 0, 0, 9
        drive(1, 1, 8, 0, 0); tick();
        check_stage("st_ex0", ex_wena, ex_waddr, 1, 8);
        check("st_cnt0", 32'(bubble_cnt), 0);
        drive(1, 1, 9, 1, 0); tick();
        check_stage("st_ex1",  ex_wena,  ex_waddr,  0, 0);
        check_stage("st_mem1", mem_wena, mem_waddr, 1, 8);
        check("st_cnt1", 32'(bubble_cnt), 1);
        tick();
        check_stage("st_ex2", ex_wena, ex_waddr, 0, 0);
        check_stage("st_wb2", wb_wena, wb_waddr, 1, 8);
        check("st_cnt2", 32'(bubble_cnt), 2);
        drive(1, 1, 9, 0, 0); tick();
        check_stage("st_ex3", ex_wena, ex_waddr, 1, 9);
        check("st_cnt3", 32'(bubble_cnt), 2);

        // Flush-only bubble is not counted
        drive(1, 1, 12, 0, 1); tick();
        check_stage("fl_ex", ex_wena, ex_waddr, 0, 0);
        check("fl_cnt", 32'(bubble_cnt), 2);

        // Writes to $0 are not tracked; neither are invalid / non-writing slots
        drive(1, 1, 0, 0, 0); tick();
        check_stage("r0_ex", ex_wena, ex_waddr, 0, 0);
        drive(0, 1, 5, 0, 0); tick();
        check_stage("inv_ex", ex_wena, ex_waddr, 0, 0);
        drive(1, 0, 6, 0, 0); tick();
        check_stage("nowr_ex", ex_wena, ex_waddr, 0, 0);

        // Stall and flush together: a single counted bubble
        drive(1, 1, 7, 1, 1); tick();
        check_stage("sf_ex", ex_wena, ex_waddr, 0, 0);
        check("sf_cnt", 32'(bubble_cnt), 3);

        // Reset in the middle of a 2-cycle stall
        drive(1, 1, 8, 0, 0); tick();
        drive(1, 1, 9, 1, 0); tick();
        check_stage("mr_mem", mem_wena, mem_waddr, 1, 8);
        check("mr_cnt", 32'(bubble_cnt), 4);
        rst = 1'b1; tick();
        check_stage("mr_ex",  ex_wena,  ex_waddr,  0, 0);
        check_stage("mr_mem0", mem_wena, mem_waddr, 0, 0);
        check_stage("mr_wb",  wb_wena,  wb_waddr,  0, 0);
        check("mr_cnt0", 32'(bubble_cnt), 0);
        check("mr_scnt0", 32'(s_bubble_cnt), 0);
        rst = 1'b0;

        // Saturation of the 2-bit counter over 5 stall cycles
        drive(1, 1, 9, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat_cnt%0d", i), 32'(s_bubble_cnt), (i < 3) ? i : 3);
            check($sformatf("wide_cnt%0d", i), 32'(bubble_cnt), i);
        end
        check_stage("sat_ex", s_ex_wena, s_ex_waddr, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
